// File: rtl/param_rom_stream_ctrl.sv
// Streams a parameter tensor from a fixed-latency ROM to a valid/ready consumer, NUM_REPEAT passes
// per start, with credit-limited address issue feeding a small first-word-fall-through buffer.
module param_rom_stream_ctrl #(
  parameter int unsigned PRECISION    = 16,
  parameter int unsigned PARALLELISM  = 1,
  parameter int unsigned OUT_DEPTH    = 32,
  parameter int unsigned ROM_LATENCY  = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_WIDTH = 8,
  parameter int unsigned AWIDTH       = $clog2(OUT_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [REPEAT_WIDTH-1:0]          num_repeat,
  output logic                             busy,
  output logic                             done,
  output logic [AWIDTH-1:0]                rom_addr,
  output logic                             rom_ce,
  input  logic [PRECISION*PARALLELISM-1:0] rom_q,
  output logic [PRECISION-1:0]             data_out [PARALLELISM],
  output logic                             data_out_valid,
  input  logic                             data_out_ready
);

  localparam int unsigned DW = PRECISION * PARALLELISM;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(ROM_LATENCY + 1);

  if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_cfg_check
    $error("param_rom_stream_ctrl: FIFO_DEPTH must be >= ROM_LATENCY+1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                  state_q;
  logic                    busy_q, done_q;
  logic [AWIDTH-1:0]       addr_cnt_q;
  logic [REPEAT_WIDTH-1:0] rep_cnt_q, num_rep_q;
  logic [ROM_LATENCY-1:0]  vld_sr_q;
  logic [IW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [DW-1:0]           mem_q [FIFO_DEPTH];
  logic                    issue, push, pop, last_addr, last_rep;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit uses registered counts only; a pop this cycle frees its slot next cycle.
  always_comb begin
    issue      = (state_q == StRun) &&
                 ((32'(fifo_cnt_q) + 32'(inflight_q)) < FIFO_DEPTH);
    push       = vld_sr_q[ROM_LATENCY-1];
    pop        = (fifo_cnt_q != '0) && data_out_ready;
    inflight_d = inflight_q + IW'(issue) - IW'(push);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    last_addr  = (addr_cnt_q == AWIDTH'(OUT_DEPTH - 1));
    last_rep   = (rep_cnt_q == num_rep_q - REPEAT_WIDTH'(1));
  end

  always_comb begin
    for (int j = 0; j < PARALLELISM; j++) begin
      data_out[j] = mem_q[rd_ptr_q][PRECISION*j +: PRECISION];
    end
  end

  assign data_out_valid = (fifo_cnt_q != '0);
  assign rom_addr       = addr_cnt_q;
  assign rom_ce         = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_cnt_q <= '0;
      rep_cnt_q  <= '0;
      num_rep_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_repeat != '0) begin
              state_q    <= StRun;
              busy_q     <= 1'b1;
              num_rep_q  <= num_repeat;
              addr_cnt_q <= '0;
              rep_cnt_q  <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (issue) begin
            if (last_addr) begin
              addr_cnt_q <= '0;
              rep_cnt_q  <= rep_cnt_q + REPEAT_WIDTH'(1);
              if (last_rep) state_q <= StDrain;
            end else begin
              addr_cnt_q <= addr_cnt_q + AWIDTH'(1);
            end
          end
        end
        StDrain: begin
          // Finish as the last beat leaves, so done lands the cycle after it.
          if ((fifo_cnt_d == '0) && (inflight_d == '0)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q   <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      vld_sr_q   <= (vld_sr_q << 1) | ROM_LATENCY'(issue);
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rom_q;
  end

endmodule

// File: doc/param_rom_stream_ctrl.md
Name: param_rom_stream_ctrl

Overview:
- Sequencer placed between a parameter ROM (registered read, fixed ROM_LATENCY) and the valid/ready consumer of that parameter tensor.
- Generates ROM addresses under a credit scheme and tracks reads in flight.
- Buffers ROM words in a small first-word-fall-through FIFO, so backpressure never loses or duplicates a beat.
- Streams the full tensor NUM_REPEAT times per start command, then pulses done.

Parameters:
- PRECISION, 16, bit width of one output element.
- PARALLELISM, 1, elements per beat; rom_q width = PRECISION*PARALLELISM.
- OUT_DEPTH, 32, ROM words per tensor pass.
- ROM_LATENCY, 2, cycles from address presented to rom_q valid (ROM ce held 1).
- FIFO_DEPTH, 4, output buffer entries. Must be >= ROM_LATENCY+1, checked at elaboration. Full throughput requires >= ROM_LATENCY+2.
- REPEAT_WIDTH, 8, width of num_repeat.
- AWIDTH, $clog2(OUT_DEPTH)+1, ROM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_repeat  in  REPEAT_WIDTH  number of tensor passes; latched on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a run completes.
- rom_addr  out  AWIDTH  ROM read address.
- rom_ce  out  1  constant 1.
- rom_q  in  PRECISION*PARALLELISM  ROM read data.
- data_out  out  PRECISION x [PARALLELISM]  unpacked array; element j = rom_q slice [PRECISION*j +: PRECISION] of the FIFO head word.
- data_out_valid  out  1  FIFO non-empty.
- data_out_ready  in  1  consumer ready.

Behaviour:
- Reset values: state IDLE; busy=0, done=0, data_out_valid=0, rom_addr=0. All counters are cleared and the in-flight pipeline and FIFO are flushed. rom_ce stays 1.
- State IDLE:
  - start=1 with num_repeat>0 → RUN next cycle; latch num_repeat; addr_cnt=0, rep_cnt=0.
  - start=1 with num_repeat=0 → done pulses next cycle; stay IDLE; no beats.
- State RUN:
  - issue = (fifo_count + inflight_count < FIFO_DEPTH). Counts are registered values; a same-cycle pop is not credited.
  - On issue: rom_addr carries addr_cnt this cycle, and a valid bit enters a ROM_LATENCY-deep shift register.
  - addr_cnt increments on issue and wraps OUT_DEPTH-1 → 0. At the wrap, rep_cnt increments.
  - The issue of address OUT_DEPTH-1 with rep_cnt = num_repeat-1 → DRAIN next cycle.
  - rom_addr holds its value when not issuing.
- State DRAIN:
  - No issues.
  - When inflight_count=0 and FIFO empty → done=1 for one cycle and state IDLE in the same cycle; busy falls with it.
- Return path: shift-register output valid in cycle t+ROM_LATENCY pushes rom_q into the FIFO at the end of that cycle. The credit rule guarantees the push never overflows.
- Output handshake:
  - A beat transfers when data_out_valid & data_out_ready.
  - data_out is stable while valid=1 and ready=0.
  - Simultaneous push and pop are allowed at any fill level, including full.
- Latency: start sampled in cycle 0 → first issue in cycle 1 → rom_q in cycle 1+ROM_LATENCY → data_out_valid in cycle 2+ROM_LATENCY (cycle 4 with defaults).
- Throughput: 1 beat/cycle while ready=1, given FIFO_DEPTH >= ROM_LATENCY+2.
- start while busy is ignored; num_repeat is not re-latched.
- rst mid-run: on the next cycle, data_out_valid=0, busy=0, no done pulse. A following start restarts from address 0.
- Total beats per run = OUT_DEPTH*num_repeat, in address order 0..OUT_DEPTH-1 repeated. No gaps or duplicates.

Test Plan:
- OUT_DEPTH=8, ROM word k = k, num_repeat=1, ready=1 → data_out_valid first high 4 cycles after start; beats 0..7 back-to-back; done 1 cycle after beat 7; busy low thereafter.
- num_repeat=3, ready=1 → 24 consecutive beats 0..7,0..7,0..7; exactly one done pulse.
- ready held 0 for 20 cycles after start → FIFO holds 0,1,2,3; rom_addr frozen at 4; inflight=0. Releasing ready → beats 0..7 in order, none lost.
- Random ready (50%), num_repeat=2 → scoreboard sees 16 beats in order; fifo_count+inflight never exceeds 4; data_out stable while stalled.
- rst asserted mid-run at beat 3 → data_out_valid=0 next cycle, no done. A new start yields beats beginning at 0.
- start pulsed during RUN, and start with num_repeat=0 in IDLE → the first has no effect on beat count; the second gives done on the next cycle with zero beats and busy staying 0.
